lix_shr_ctrl: RTL and testbench

//  Flow controller for an N-stage global-enable pipeline register chain (lix_shr0 style).

---
 rtl/lix_shr_ctrl_pkg.sv | 16 +
 rtl/lix_shr_ctrl_if.sv | 38 +++
 rtl/lix_shr_ctrl_vld_chain.sv | 34 +++
 rtl/lix_shr_ctrl.sv | 104 ++++++++++
 tb/tb_lix_shr_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/lix_shr_ctrl_pkg.sv
// Purpose : shared types and helpers for the lix_shr pipeline flow controller.
// Contents: lix_shr_st_e  - controller state encoding
//           cnt_w()       - width of an occupancy count able to hold 0..n
package lix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lix_shr_st_e;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lix_shr_ctrl_if.sv
// Purpose : handshake/control bundle between the flow controller and its
//           environment (upstream source, downstream sink, chain control).
// Signals : i_vld/o_rdy   upstream handshake
//           o_vld/i_rdy   downstream handshake
//           o_en/o_dvld   chain shift enable and stage-0 capture valid
//           i_drain/i_flush, o_cnt/o_idle/o_done  control and status
// Modports: slave  - the controller
//           master - the environment driving it
interface lix_shr_ctrl_if #(
  parameter int N = 2
);
  import lix_pkg::*;

  localparam int CW = cnt_w(N);

  logic          i_vld;
  logic          o_rdy;
  logic          o_en;
  logic          o_dvld;
  logic          o_vld;
  logic          i_rdy;
  logic          i_drain;
  logic          i_flush;
  logic [CW-1:0] o_cnt;
  logic          o_idle;
  logic          o_done;

  modport slave (
    input  i_vld, i_rdy, i_drain, i_flush,
    output o_rdy, o_en, o_dvld, o_vld, o_cnt, o_idle, o_done
  );

  modport master (
    output i_vld, i_rdy, i_drain, i_flush,
    input  o_rdy, o_en, o_dvld, o_vld, o_cnt, o_idle, o_done
  );

endinterface

// File: rtl/lix_shr_ctrl_vld_chain.sv
// Purpose : shadow copy of the valid bit of every stage of the controlled
//           global-enable register chain; o_v[N-1] is the output stage.
// Ports   : clk_i, rst_ni (sync, active-low)
//           i_en    shift enable (same enable the chain sees)
//           i_flush clear all valid bits
//           i_vld   valid captured into stage 0 on a shift
//           o_v     per-stage valid bits
module lix_vld_chain #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_en,
  input  logic         i_flush,
  input  logic         i_vld,
  output logic [N-1:0] o_v
);

  if (N == 1) begin : g_one
    // NOTE: reset is sampled on the clock edge (synchronous) and all state
    // is written with non-blocking assignments so every register sees the
    // pre-edge values of the others.
    always_ff @(posedge clk_i) begin
      if (!rst_ni || i_flush) o_v <= '0;
      else if (i_en)          o_v <= i_vld;
    end
  end else begin : g_many
    always_ff @(posedge clk_i) begin
      if (!rst_ni || i_flush) o_v <= '0;
      else if (i_en)          o_v <= {o_v[N-2:0], i_vld};
    end
  end

endmodule

// File: rtl/lix_shr_ctrl.sv
// Purpose : flow controller for an N-stage global-enable pipeline chain.
//           Maps upstream/downstream valid/ready onto the chain's single
//           shift enable and stage-0 valid, tracks occupancy, and supports
//           drain (empty then pulse done) and flush (discard everything).
// Ports   : clk_i  clock
//           rst_ni synchronous active-low reset
//           bus    lix_shr_ctrl_if.slave handshake/control bundle
module lix_shr_ctrl
  import lix_pkg::*;
#(
  parameter int N = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  lix_shr_ctrl_if.slave  bus
);

  localparam int CW = cnt_w(N);

  logic [N-1:0]  v;
  logic          en;
  logic          en_out;
  logic          accept;
  logic          retire;
  logic [CW-1:0] cnt_q, cnt_d;
  lix_shr_st_e   state_q, state_d;
  logic          done_q, done_d;

  // The chain advances whenever its output stage is empty or being consumed;
  // internal bubbles are not squeezed out. Flush freezes the chain for the
  // cycle it is asserted.
  assign en      = ~v[N-1] | bus.i_rdy;
  assign en_out  = en & ~bus.i_flush;
  assign accept  = bus.i_vld & bus.o_rdy;
  assign retire  = bus.o_vld & bus.i_rdy;

  assign bus.o_en   = en_out;
  assign bus.o_rdy  = en & (state_q != DRAIN) & ~bus.i_flush;
  assign bus.o_dvld = accept;
  assign bus.o_vld  = v[N-1] & ~bus.i_flush;
  assign bus.o_cnt  = cnt_q;
  assign bus.o_idle = (state_q == IDLE);
  assign bus.o_done = done_q;

  lix_vld_chain #(.N(N)) u_vld_chain (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_en    (en_out),
    .i_flush (bus.i_flush),
    .i_vld   (accept),
    .o_v     (v)
  );

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cnt_d = cnt_q;
    if (accept && !retire)      cnt_d = cnt_q + CW'(1);
    else if (!accept && retire) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept)           state_d = bus.i_drain ? DRAIN : RUN;
          else if (bus.i_drain) done_d  = 1'b1;
        end
        RUN: begin
          if (cnt_d == '0) begin
            state_d = IDLE;
            done_d  = bus.i_drain;
          end else if (bus.i_drain) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= bus.i_flush ? '0 : cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_lix_shr_ctrl.sv
// Purpose : self-checking bench for lix_shr_ctrl (N=3 main instance, N=1
//           instance for the single-stage corner). A behavioural model of
//           the controlled chain (data + valid per stage) runs off the DUT's
//           o_en/o_dvld; accepted tags go into a scoreboard queue and are
//           compared against the modelled chain output on every retire.
module tb_lix_shr_ctrl;
  import lix_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lix_shr_ctrl_if #(.N(N)) bus ();
  lix_shr_ctrl_if #(.N(1)) bus1 ();

  lix_shr_ctrl #(.N(N)) dut  (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  lix_shr_ctrl #(.N(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

  // Chain model: what the real lix_shr0 chain holds, plus intended validity.
  logic [N-1:0] rv;
  logic [7:0]   rd [N];
  logic [7:0]   data_in;

  always @(posedge clk) begin
    if (!rst_n || bus.i_flush) begin
      rv <= '0;
    end else if (bus.o_en) begin
      rv <= {rv[N-2:0], bus.o_dvld};
    end
    if (bus.o_en) begin
      rd[0] <= data_in;
      for (int k = 1; k < N; k++) rd[k] <= rd[k-1];
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q [$];
  logic [7:0] tag = 8'd1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic vld, rdy, drn, fls;
    logic e_rdy, e_en, e_vld;
    int   e_cnt;
    logic e_idle, e_done;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic vld, rdy, drn, fls,
                              input logic e_rdy, e_en, e_vld, input int e_cnt,
                              input logic e_idle, e_done);
    vec_t t;
    t.vld = vld; t.rdy = rdy; t.drn = drn; t.fls = fls;
    t.e_rdy = e_rdy; t.e_en = e_en; t.e_vld = e_vld; t.e_cnt = e_cnt;
    t.e_idle = e_idle; t.e_done = e_done;
    return t;
  endfunction

  task automatic run_vec(input int idx, input vec_t t);
    @(negedge clk);
    bus.i_vld = t.vld; bus.i_rdy = t.rdy; bus.i_drain = t.drn; bus.i_flush = t.fls;
    data_in = tag;
    #1;
    check($sformatf("r%0d_rdy", idx),  bus.o_rdy,  t.e_rdy);
    check($sformatf("r%0d_en", idx),   bus.o_en,   t.e_en);
    check($sformatf("r%0d_vld", idx),  bus.o_vld,  t.e_vld);
    check($sformatf("r%0d_cnt", idx),  bus.o_cnt,  t.e_cnt);
    check($sformatf("r%0d_idle", idx), bus.o_idle, t.e_idle);
    check($sformatf("r%0d_done", idx), bus.o_done, t.e_done);
    check($sformatf("r%0d_dvld", idx), bus.o_dvld, t.vld & t.e_rdy);
    check($sformatf("r%0d_shadow_vld", idx), bus.o_vld, rv[N-1] & ~t.fls);
    check($sformatf("r%0d_shadow_cnt", idx), bus.o_cnt, $countones(rv));
    if (t.e_vld && t.rdy) begin
      check($sformatf("r%0d_sb_nonempty", idx), int'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) check($sformatf("r%0d_data", idx), rd[N-1], sb_q.pop_front());
    end
    if (t.vld && t.e_rdy) begin
      sb_q.push_back(tag);
      tag++;
    end
    if (t.fls) sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming: 6 accepts back to back, then empty out.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,0,0, 1,1,0,i, i==0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,0,0, 1,1,1,3, 0,0));
    vecs.push_back(mk(0,1,0,0, 1,1,1,3, 0,0));
    vecs.push_back(mk(0,1,0,0, 1,1,1,2, 0,0));
    vecs.push_back(mk(0,1,0,0, 1,1,1,1, 0,0));
    vecs.push_back(mk(0,1,0,0, 1,1,0,0, 1,0));
    // Bubbles: accepts on cycles 0 and 2 only.
    vecs.push_back(mk(1,1,0,0, 1,1,0,0, 1,0));
    vecs.push_back(mk(0,1,0,0, 1,1,0,1, 0,0));
    vecs.push_back(mk(1,1,0,0, 1,1,0,1, 0,0));
    vecs.push_back(mk(0,1,0,0, 1,1,1,2, 0,0));
    vecs.push_back(mk(0,1,0,0, 1,1,0,1, 0,0));
    vecs.push_back(mk(0,1,0,0, 1,1,1,1, 0,0));
    vecs.push_back(mk(0,1,0,0, 1,1,0,0, 1,0));
    // Backpressure: fill, stall 4 cycles, release.
    vecs.push_back(mk(1,0,0,0, 1,1,0,0, 1,0));
    vecs.push_back(mk(1,0,0,0, 1,1,0,1, 0,0));
    vecs.push_back(mk(1,0,0,0, 1,1,0,2, 0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0, 0,0,1,3, 0,0));
    vecs.push_back(mk(1,1,0,0, 1,1,1,3, 0,0));
    vecs.push_back(mk(0,1,0,0, 1,1,1,3, 0,0));
    // Drain with 2 in flight; then drain from IDLE.
    vecs.push_back(mk(0,0,1,0, 0,0,1,2, 0,0));
    vecs.push_back(mk(1,1,0,0, 0,1,1,2, 0,0));
    vecs.push_back(mk(1,1,0,0, 0,1,1,1, 0,0));
    vecs.push_back(mk(0,1,0,0, 1,1,0,0, 1,1));
    vecs.push_back(mk(0,1,0,0, 1,1,0,0, 1,0));
    vecs.push_back(mk(0,1,1,0, 1,1,0,0, 1,0));
    vecs.push_back(mk(0,1,0,0, 1,1,0,0, 1,1));
    vecs.push_back(mk(0,1,0,0, 1,1,0,0, 1,0));
    // Flush together with drain while full and stalled.
    vecs.push_back(mk(1,0,0,0, 1,1,0,0, 1,0));
    vecs.push_back(mk(1,0,0,0, 1,1,0,1, 0,0));
    vecs.push_back(mk(1,0,0,0, 1,1,0,2, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,1,3, 0,0));
    vecs.push_back(mk(1,0,1,1, 0,0,0,3, 0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,0,0, 1,0));
    vecs.push_back(mk(0,0,0,0, 1,1,0,0, 1,0));

    rst_n = 1'b0;
    bus.i_vld = 0; bus.i_rdy = 1; bus.i_drain = 0; bus.i_flush = 0;
    bus1.i_vld = 0; bus1.i_rdy = 1; bus1.i_drain = 0; bus1.i_flush = 0;
    data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_cnt",  bus.o_cnt,  0);
    check("reset_vld",  bus.o_vld,  0);
    check("reset_en",   bus.o_en,   1);
    check("reset_rdy",  bus.o_rdy,  1);
    check("reset_idle", bus.o_idle, 1);
    check("reset_done", bus.o_done, 0);

    foreach (vecs[i]) run_vec(i, vecs[i]);
    check("sb_empty_after_table", sb_q.size(), 0);

    // Reset mid-stream with two entries in flight.
    run_vec(100, mk(1,0,0,0, 1,1,0,0, 1,0));
    run_vec(101, mk(1,0,0,0, 1,1,0,1, 0,0));
    @(negedge clk);
    bus.i_vld = 0;
    #1;
    check("pre_rst_cnt", bus.o_cnt, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    #1;
    check("mid_rst_cnt",    bus.o_cnt,  0);
    check("mid_rst_vld",    bus.o_vld,  0);
    check("mid_rst_rdy",    bus.o_rdy,  1);
    check("mid_rst_idle",   bus.o_idle, 1);
    check("mid_rst_shadow", $countones(rv), 0);

    // Single-stage build: fill, stall, stream through full, reset.
    @(negedge clk);
    bus1.i_vld = 1; bus1.i_rdy = 0;
    #1;
    check("n1_rdy0", bus1.o_rdy, 1);
    check("n1_vld0", bus1.o_vld, 0);
    check("n1_cnt0", bus1.o_cnt, 0);
    @(negedge clk);
    #1;
    check("n1_full_rdy", bus1.o_rdy, 0);
    check("n1_full_en",  bus1.o_en,  0);
    check("n1_full_vld", bus1.o_vld, 1);
    check("n1_full_cnt", bus1.o_cnt, 1);
    bus1.i_rdy = 1;
    #1;
    check("n1_pass_rdy",  bus1.o_rdy,  1);
    check("n1_pass_dvld", bus1.o_dvld, 1);
    @(negedge clk);
    #1;
    check("n1_pass_cnt", bus1.o_cnt, 1);
    check("n1_pass_vld", bus1.o_vld, 1);
    bus1.i_vld = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("n1_rst_cnt",  bus1.o_cnt,  0);
    check("n1_rst_vld",  bus1.o_vld,  0);
    check("n1_rst_rdy",  bus1.o_rdy,  1);
    check("n1_rst_idle", bus1.o_idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
